// File: rtl/vp_mode_ctrl_if.sv
// rtl/vp_mode_ctrl_if.sv - switch, frame-sync and mode-status signals of the mode controller
interface vp_mode_ctrl_if;
  logic [2:0]  sw_raw;
  logic        auto_en_raw;
  logic        v_sync_in;
  logic [2:0]  mode_out;
  logic        mode_changed;
  logic [15:0] frame_cnt;
  logic        busy;

  modport master (
    output sw_raw, auto_en_raw, v_sync_in,
    input  mode_out, mode_changed, frame_cnt, busy
  );

  modport slave (
    input  sw_raw, auto_en_raw, v_sync_in,
    output mode_out, mode_changed, frame_cnt, busy
  );
endinterface

// File: rtl/vp_mode_ctrl.sv
// rtl/vp_mode_ctrl.sv - debounced, frame-aligned video pipeline tap selector with auto-cycle
module vp_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_MODES       = 5,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  vp_mode_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {WAIT_FRAME, RUN, PENDING} state_t;

  logic [2:0]    sw_meta_q, sw_sync_q, sw_last_q, sw_stable_q;
  logic [DW-1:0] sw_cnt_q;
  logic          auto_meta_q, auto_sync_q, auto_last_q, auto_stable_q;
  logic [DW-1:0] auto_cnt_q;
  logic          vs_prev_q;
  logic [15:0]   frame_cnt_q;
  logic [AW-1:0] auto_frm_q;
  state_t        state_q, state_d;
  logic [2:0]    mode_out_q, mode_out_d;
  logic          mode_changed_q, mode_changed_d;
  logic [2:0]    req_mode;
  logic          frame_start;

  assign frame_start = bus.v_sync_in & ~vs_prev_q;

  // Two-flop synchronizers for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      auto_meta_q <= 1'b0;
      auto_sync_q <= 1'b0;
    end else begin
      sw_meta_q   <= bus.sw_raw;
      sw_sync_q   <= sw_meta_q;
      auto_meta_q <= bus.auto_en_raw;
      auto_sync_q <= auto_meta_q;
    end
  end

  // Mode switch debounce: any change restarts the count, the count saturates while held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_last_q   <= '0;
      sw_cnt_q    <= '0;
      sw_stable_q <= '0;
    end else begin
      sw_last_q <= sw_sync_q;
      if (sw_sync_q != sw_last_q)  sw_cnt_q    <= '0;
      else if (sw_cnt_q != DB_LAST) sw_cnt_q   <= sw_cnt_q + DW'(1);
      else                          sw_stable_q <= sw_sync_q;
    end
  end

  // Auto-enable switch debounce, same scheme as the mode switch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_last_q   <= 1'b0;
      auto_cnt_q    <= '0;
      auto_stable_q <= 1'b0;
    end else begin
      auto_last_q <= auto_sync_q;
      if (auto_sync_q != auto_last_q) auto_cnt_q    <= '0;
      else if (auto_cnt_q != DB_LAST)  auto_cnt_q   <= auto_cnt_q + DW'(1);
      else                             auto_stable_q <= auto_sync_q;
    end
  end

  // Frame-start edge detect and wrapping frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_prev_q <= bus.v_sync_in;
      if (frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Auto-cycle frame counter: parked at 0 whenever auto-cycle is off
  always_ff @(posedge clk) begin
    if (!rst_n || !auto_stable_q) begin
      auto_frm_q <= '0;
    end else if (frame_start) begin
      auto_frm_q <= (auto_frm_q == AF_LAST) ? '0 : auto_frm_q + AW'(1);
    end
  end

  // Requested mode: auto steps from the live mode_out; manual maps out-of-range taps to 0
  always_comb begin
    req_mode = 3'd0;
    if (auto_stable_q) begin
      req_mode = mode_out_q;
      if (frame_start && (auto_frm_q == AF_LAST)) begin
        req_mode = (int'(mode_out_q) >= NUM_MODES - 1) ? 3'd0 : mode_out_q + 3'd1;
      end
    end else if (int'(sw_stable_q) < NUM_MODES) begin
      req_mode = sw_stable_q;
    end
  end

  // Next state and output load: a differing request is only ever taken on a frame start
  always_comb begin
    state_d        = state_q;
    mode_out_d     = mode_out_q;
    mode_changed_d = 1'b0;
    if (frame_start && (req_mode != mode_out_q)) begin
      mode_out_d     = req_mode;
      mode_changed_d = 1'b1;
    end
    case (state_q)
      WAIT_FRAME: if (frame_start) state_d = RUN;
      RUN:        if (!frame_start && (req_mode != mode_out_q)) state_d = PENDING;
      PENDING:    if (frame_start || (req_mode == mode_out_q)) state_d = RUN;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // State and registered mode outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= WAIT_FRAME;
      mode_out_q     <= '0;
      mode_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_out_q     <= mode_out_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign bus.mode_out     = mode_out_q;
  assign bus.mode_changed = mode_changed_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.busy         = (state_q == PENDING);
endmodule

// File: tb/tb_vp_mode_ctrl.sv
// tb/tb_vp_mode_ctrl.sv - self-checking bench for vp_mode_ctrl with a mode-change scoreboard
module tb_vp_mode_ctrl;
  localparam int DEB = 4;
  localparam int NM  = 5;
  localparam int AF  = 3;

  logic clk = 1'b0;
  logic rst_n;

  vp_mode_ctrl_if bus ();

  vp_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_MODES(NM),
    .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          pulse_cnt    = 0;
  logic [2:0]  exp_q[$];
  logic [15:0] fc_exp;

  // Scoreboard: every mode_changed pulse must match the oldest expected mode
  always @(negedge clk) begin
    if (bus.mode_changed === 1'b1) begin
      logic [2:0] e;
      pulse_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_change: got mode %0d want no change", bus.mode_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.mode_out !== e) begin
          tests_failed++;
          $display("FAIL sb_mode: got %0d want %0d", bus.mode_out, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    bus.v_sync_in = 1'b1;
    @(negedge clk);
    bus.v_sync_in = 1'b0;
    fc_exp = fc_exp + 16'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sw_raw = 3'd2;
    bus.auto_en_raw = 1'b0;
    bus.v_sync_in = 1'b0;
    tick(3);
    tests_run++; if (bus.mode_out !== 3'd0) begin tests_failed++; $display("FAIL reset_mode_out: got %0d want 0", bus.mode_out); end
    tests_run++; if (bus.mode_changed !== 1'b0) begin tests_failed++; $display("FAIL reset_mode_changed: got %0b want 0", bus.mode_changed); end
    tests_run++; if (bus.frame_cnt !== 16'h0000) begin tests_failed++; $display("FAIL reset_frame_cnt: got %0h want 0", bus.frame_cnt); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    fc_exp = 16'h0000;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    int p0;
    tick(50);
    tests_run++; if (bus.mode_out !== 3'd0) begin tests_failed++; $display("FAIL wait_mode_out: got %0d want 0", bus.mode_out); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL wait_busy: got %0b want 0", bus.busy); end
    p0 = pulse_cnt;
    exp_q.push_back(3'd2);
    bus.v_sync_in = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.mode_out !== 3'd2) begin tests_failed++; $display("FAIL first_frame_latency: got %0d want 2", bus.mode_out); end
    bus.v_sync_in = 1'b0;
    fc_exp = fc_exp + 16'd1;
    tick(6);
    tests_run++; if (pulse_cnt - p0 !== 1) begin tests_failed++; $display("FAIL first_frame_pulses: got %0d want 1", pulse_cnt - p0); end
    tests_run++; if (bus.frame_cnt !== fc_exp) begin tests_failed++; $display("FAIL first_frame_cnt: got %0h want %0h", bus.frame_cnt, fc_exp); end
  endtask

  task automatic test_glitch();
    int   p0;
    logic busy_seen;
    bus.sw_raw = 3'd1;
    tick(15);
    exp_q.push_back(3'd1);
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd1) begin tests_failed++; $display("FAIL glitch_setup: got %0d want 1", bus.mode_out); end
    p0 = pulse_cnt;
    bus.sw_raw = 3'd3;
    tick(3);
    bus.sw_raw = 3'd1;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_seen = 1'b1;
    end
    tests_run++; if (busy_seen !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %0b want 0", busy_seen); end
    vsync_pulse();
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd1) begin tests_failed++; $display("FAIL glitch_mode: got %0d want 1", bus.mode_out); end
    tests_run++; if (pulse_cnt - p0 !== 0) begin tests_failed++; $display("FAIL glitch_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_pending();
    bus.sw_raw = 3'd0;
    tick(15);
    exp_q.push_back(3'd0);
    vsync_pulse();
    bus.sw_raw = 3'd4;
    tick(15);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL pending_busy: got %0b want 1", bus.busy); end
    tests_run++; if (bus.mode_out !== 3'd0) begin tests_failed++; $display("FAIL pending_hold: got %0d want 0", bus.mode_out); end
    exp_q.push_back(3'd4);
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd4) begin tests_failed++; $display("FAIL pending_apply: got %0d want 4", bus.mode_out); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL pending_done_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_cancel();
    int p0;
    bus.sw_raw = 3'd1;
    tick(15);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL cancel_busy: got %0b want 1", bus.busy); end
    bus.sw_raw = 3'd4;
    tick(15);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL cancel_idle: got %0b want 0", bus.busy); end
    p0 = pulse_cnt;
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd4) begin tests_failed++; $display("FAIL cancel_mode: got %0d want 4", bus.mode_out); end
    tests_run++; if (pulse_cnt - p0 !== 0) begin tests_failed++; $display("FAIL cancel_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_invalid();
    int p0;
    bus.sw_raw = 3'd6;
    tick(15);
    exp_q.push_back(3'd0);
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd0) begin tests_failed++; $display("FAIL invalid_map: got %0d want 0", bus.mode_out); end
    bus.sw_raw = 3'd7;
    tick(15);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL invalid_busy: got %0b want 0", bus.busy); end
    p0 = pulse_cnt;
    vsync_pulse();
    tests_run++; if (pulse_cnt - p0 !== 0) begin tests_failed++; $display("FAIL invalid_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_auto();
    logic [2:0] cur;
    bus.sw_raw = 3'd3;
    tick(15);
    exp_q.push_back(3'd3);
    vsync_pulse();
    cur = 3'd3;
    bus.auto_en_raw = 1'b1;
    tick(15);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL auto_enable_busy: got %0b want 0", bus.busy); end
    for (int k = 1; k <= 9; k++) begin
      if (k % AF == 0) begin
        cur = (cur == 3'(NM - 1)) ? 3'd0 : cur + 3'd1;
        exp_q.push_back(cur);
      end
      vsync_pulse();
      tests_run++; if (bus.mode_out !== cur) begin tests_failed++; $display("FAIL auto_step_%0d: got %0d want %0d", k, bus.mode_out, cur); end
      tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL auto_busy_%0d: got %0b want 0", k, bus.busy); end
    end
    bus.auto_en_raw = 1'b0;
    bus.sw_raw = 3'd2;
    tick(15);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL auto_off_busy: got %0b want 1", bus.busy); end
    exp_q.push_back(3'd2);
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd2) begin tests_failed++; $display("FAIL auto_off_mode: got %0d want 2", bus.mode_out); end
    tests_run++; if (bus.frame_cnt !== fc_exp) begin tests_failed++; $display("FAIL auto_frame_cnt: got %0h want %0h", bus.frame_cnt, fc_exp); end
  endtask

  task automatic test_reset_pending();
    while (fc_exp != 16'h0123) vsync_pulse();
    tests_run++; if (bus.frame_cnt !== 16'h0123) begin tests_failed++; $display("FAIL rp_frame_cnt: got %0h want 123", bus.frame_cnt); end
    bus.sw_raw = 3'd4;
    tick(15);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rp_busy: got %0b want 1", bus.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fc_exp = 16'h0000;
    tests_run++; if (bus.mode_out !== 3'd0) begin tests_failed++; $display("FAIL rp_mode_out: got %0d want 0", bus.mode_out); end
    tests_run++; if (bus.mode_changed !== 1'b0) begin tests_failed++; $display("FAIL rp_mode_changed: got %0b want 0", bus.mode_changed); end
    tests_run++; if (bus.frame_cnt !== 16'h0000) begin tests_failed++; $display("FAIL rp_frame_zero: got %0h want 0", bus.frame_cnt); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rp_busy_zero: got %0b want 0", bus.busy); end
    tick(30);
    tests_run++; if (bus.mode_out !== 3'd0) begin tests_failed++; $display("FAIL rp_wait_mode: got %0d want 0", bus.mode_out); end
    exp_q.push_back(3'd4);
    vsync_pulse();
    tests_run++; if (bus.mode_out !== 3'd4) begin tests_failed++; $display("FAIL rp_resume_mode: got %0d want 4", bus.mode_out); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    dut.frame_cnt_q = 16'hFFFF;
    fc_exp = 16'hFFFF;
    tick(2);
    tests_run++; if (bus.frame_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_preload: got %0h want ffff", bus.frame_cnt); end
    vsync_pulse();
    tests_run++; if (bus.frame_cnt !== 16'h0000) begin tests_failed++; $display("FAIL wrap_frame_cnt: got %0h want 0", bus.frame_cnt); end
    tests_run++; if (bus.frame_cnt !== fc_exp) begin tests_failed++; $display("FAIL wrap_model: got %0h want %0h", bus.frame_cnt, fc_exp); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_glitch();
    test_pending();
    test_cancel();
    test_invalid();
    test_auto();
    test_reset_pending();
    test_wrap();
    tick(5);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
